spi_tx_arbiter: RTL and testbench
=================================

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024, sets the number of cycles to wait for slave busy after trigger; legal range 2..65535.
REQ-002 CLK  input  1  single clock; all logic on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  4  per-requester transmit request, level.
REQ-005 req_type  input  4x3  per-requester message type: 001 one byte, 010 two bytes, 011 three bytes, 110 six bytes, 111 long.
REQ-006 req_data  input  4x128  per-requester payload; MSB-first from the top active bit.
REQ-007 req_bytes  input  4x7  per-requester byte count, used only for type 111.
REQ-008 gnt  output  4  one-hot grant, held for the whole transaction.
REQ-009 ack  output  4  one-cycle completion pulse to the granted requester.
REQ-010 err  output  1  one-cycle pulse, coincident with ack, when the transaction failed.
REQ-011 spi_busy  input  1  busy from the SPI slave.
REQ-012 send_trigger  output  1  transmit trigger to the SPI slave.
REQ-013 spi_msg_type  output  3  SPI_MSG_TYPE to the slave.
REQ-014 spi_out_data  output  128  output_data to the slave.
REQ-015 spi_byte_cnt  output  7  InMsgByteCount to the slave.

Function
REQ-016 The FSM states SHALL be IDLE, LOAD, TRIG, WAIT_BUSY, WAIT_IDLE and DONE.
REQ-017 IDLE -> LOAD SHALL occur when any req is high and spi_busy is 0; with spi_busy high, no grant is issued, so a slave receive in progress blocks arbitration.
REQ-018 Selection SHALL be round-robin, starting at the index after the last acked requester; after reset, index 0 has highest priority.
REQ-019 LOAD SHALL register gnt plus the winner's type, data and byte count into spi_msg_type, spi_out_data and spi_byte_cnt.
REQ-020 These registered outputs SHALL stay stable until DONE exits.
REQ-021 LOAD SHALL go to DONE with err=1 and no trigger when the type is 000, 100 or 101, or when it is 111 with req_bytes=0 or req_bytes>16; otherwise LOAD -> TRIG.
REQ-022 TRIG SHALL assert send_trigger for exactly one cycle, then go to WAIT_BUSY.
REQ-023 Latency: send_trigger SHALL be high two cycles after the IDLE cycle that samples req.
REQ-024 WAIT_BUSY -> WAIT_IDLE SHALL occur on spi_busy=1.
REQ-025 WAIT_IDLE -> DONE SHALL occur on the first spi_busy=0.
REQ-026 DONE SHALL pulse ack[granted] for one cycle, update the round-robin pointer, clear gnt and return to IDLE.
REQ-027 req deasserting after LOAD SHALL NOT abort the transaction; it completes and is acked.
REQ-028 A requester holding req through DONE SHALL be re-arbitrated no earlier than the next IDLE cycle.
REQ-029 Simultaneous requests SHALL be served in round-robin order with no starvation; the worst-case wait is 3 transactions.
REQ-030 The FSM SHALL be strictly one transaction at a time; no pipelining.

Reset
REQ-031 RST_N low SHALL asynchronously clear: state to IDLE, gnt, ack, err, send_trigger, spi_msg_type, spi_out_data, spi_byte_cnt, round-robin pointer to 0, and the timeout counter.
REQ-032 Reset mid-transaction SHALL drop it with no ack.
REQ-033 The first arbitration after RST_N rises SHALL occur no earlier than the second rising edge.

Configuration
REQ-034 With macro SPI_TX_ARB_TIMEOUT_EN defined, WAIT_BUSY SHALL count cycles.
REQ-035 With the macro defined, reaching TIMEOUT_CYC without spi_busy=1 SHALL go to DONE with err=1; the counter clears on TRIG.
REQ-036 With the macro undefined, WAIT_BUSY SHALL wait indefinitely, there is no counter logic, and err is raised only by REQ-021.

Verification
REQ-037 req=0001, type 010, data 0xA5C3; slave model busy rises 2 cycles after trigger, falls 20 cycles later -> send_trigger 2 cycles after req, spi_out_data=0xA5C3, ack=0001, err=0.
REQ-038 req=1111 held continuously for 8 transactions -> ack order 0,1,2,3,0,1,2,3; gnt always one-hot.
REQ-039 spi_busy=1 (receive in progress) for 50 cycles while req=0010 -> gnt stays 0 until spi_busy falls, then the transfer proceeds.
REQ-040 req=0100, type 111, req_bytes=0 -> ack=0100 with err=1, send_trigger never asserted.
REQ-041 With SPI_TX_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, slave never busy -> ack plus err 16 cycles after the trigger; without the macro, the FSM stays in WAIT_BUSY.
REQ-042 RST_N pulsed low during WAIT_IDLE -> all outputs 0 immediately, no ack; next request granted to index 0 first.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: 4-way round-robin arbiter that hands one transmit request at a time to an SPI slave.
// Optional macro SPI_TX_ARB_TIMEOUT_EN adds a bounded wait for slave busy after the trigger.
`default_nettype none

module spi_tx_arbiter #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        i_req,
  input  logic [3:0][2:0]   i_req_type,
  input  logic [3:0][127:0] i_req_data,
  input  logic [3:0][6:0]   i_req_bytes,
  output logic [3:0]        o_gnt,
  output logic [3:0]        o_ack,
  output logic              o_err,
  input  logic              i_spi_busy,
  output logic              o_send_trigger,
  output logic [2:0]        o_spi_msg_type,
  output logic [127:0]      o_spi_out_data,
  output logic [6:0]        o_spi_byte_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    TRIG      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_IDLE = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t       r_state, w_next;
  logic         r_arm;
  logic [1:0]   r_ptr, r_idx;
  logic [3:0]   r_gnt, r_ack;
  logic         r_err, r_trig;
  logic [2:0]   r_type;
  logic [127:0] r_data;
  logic [6:0]   r_bytes;

  logic         w_load, w_fin, w_fin_err, w_trig, w_bad, w_tmo;
  logic [1:0]   w_win_idx;
  logic [1:0]   w_cand;

  function automatic logic [6:0] f_bytes(input logic [2:0] t, input logic [6:0] b);
    case (t)
      3'b001:  f_bytes = 7'd1;
      3'b010:  f_bytes = 7'd2;
      3'b011:  f_bytes = 7'd3;
      3'b110:  f_bytes = 7'd6;
      3'b111:  f_bytes = b;
      default: f_bytes = 7'd0;
    endcase
  endfunction

  // Scan from the farthest offset down so the requester nearest r_ptr wins.
  always_comb begin
    w_win_idx = r_ptr;
    w_cand    = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (i_req[w_cand]) w_win_idx = w_cand;
    end
  end

  always_comb begin
    w_bad = 1'b0;
    case (r_type)
      3'b000, 3'b100, 3'b101: w_bad = 1'b1;
      3'b111:                 w_bad = (r_bytes == 7'd0) || (r_bytes > 7'd16);
      default:                w_bad = 1'b0;
    endcase
  end

`ifdef SPI_TX_ARB_TIMEOUT_EN
  logic [15:0] r_tcnt;

  // r_tcnt equals the number of cycles elapsed since the trigger cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= 16'd0;
    end else if (r_state == TRIG) begin
      r_tcnt <= 16'd1;
    end else if (r_state == WAIT_BUSY) begin
      r_tcnt <= r_tcnt + 16'd1;
    end
  end

  assign w_tmo = (r_tcnt == 16'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_fin     = 1'b0;
    w_fin_err = 1'b0;
    w_trig    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_arm && (|i_req) && !i_spi_busy) begin
          w_next = LOAD;
          w_load = 1'b1;
        end
      end
      LOAD: begin
        if (w_bad) begin
          w_next    = DONE;
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end else begin
          w_next = TRIG;
          w_trig = 1'b1;
        end
      end
      TRIG: w_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (i_spi_busy) begin
          w_next = WAIT_IDLE;
        end else if (w_tmo) begin
          w_next    = DONE;
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!i_spi_busy) begin
          w_next = DONE;
          w_fin  = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm   <= 1'b0;
      r_ptr   <= 2'd0;
      r_idx   <= 2'd0;
      r_gnt   <= 4'd0;
      r_ack   <= 4'd0;
      r_err   <= 1'b0;
      r_trig  <= 1'b0;
      r_type  <= 3'd0;
      r_data  <= 128'd0;
      r_bytes <= 7'd0;
    end else begin
      r_arm  <= 1'b1;
      r_trig <= w_trig;
      r_ack  <= w_fin ? r_gnt : 4'd0;
      r_err  <= w_fin_err;
      if (w_load) begin
        r_gnt   <= 4'b0001 << w_win_idx;
        r_idx   <= w_win_idx;
        r_type  <= i_req_type[w_win_idx];
        r_data  <= i_req_data[w_win_idx];
        r_bytes <= f_bytes(i_req_type[w_win_idx], i_req_bytes[w_win_idx]);
      end
      if (r_state == DONE) begin
        r_gnt <= 4'd0;
        r_ptr <= r_idx + 2'd1;
      end
    end
  end

  assign o_gnt          = r_gnt;
  assign o_ack          = r_ack;
  assign o_err          = r_err;
  assign o_send_trigger = r_trig;
  assign o_spi_msg_type = r_type;
  assign o_spi_out_data = r_data;
  assign o_spi_byte_cnt = r_bytes;

endmodule

`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
// Directed self-checking bench for spi_tx_arbiter with a simple SPI slave busy model.
`default_nettype none

module tb_spi_tx_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req;
  logic [3:0][2:0]   req_type;
  logic [3:0][127:0] req_data;
  logic [3:0][6:0]   req_bytes;
  logic [3:0]        gnt, ack;
  logic              err, trig;
  logic [2:0]        msg_type;
  logic [127:0]      out_data;
  logic [6:0]        byte_cnt;
  logic              model_busy, force_busy, slave_en;
  wire               spi_busy = model_busy | force_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_tx_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req          (req),
    .i_req_type     (req_type),
    .i_req_data     (req_data),
    .i_req_bytes    (req_bytes),
    .o_gnt          (gnt),
    .o_ack          (ack),
    .o_err          (err),
    .i_spi_busy     (spi_busy),
    .o_send_trigger (trig),
    .o_spi_msg_type (msg_type),
    .o_spi_out_data (out_data),
    .o_spi_byte_cnt (byte_cnt)
  );

  // Slave: busy rises two cycles after the trigger and stays high for 20 cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (slave_en && trig) begin
        @(negedge clk);
        model_busy = 1'b1;
        repeat (20) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int bound, output int cyc, output bit saw_trig, output bit bad_oh);
    cyc = 0; saw_trig = 0; bad_oh = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (trig) saw_trig = 1;
      if ($countones(gnt) > 1) bad_oh = 1;
    end while (ack == 4'd0 && cyc < bound);
  endtask

  int  cyc;
  bit  st, boh, flag;

  initial begin
    rst_n = 1'b0; req = 4'd0; req_type = '0; req_data = '0; req_bytes = '0;
    force_busy = 1'b0; slave_en = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_trig", trig, 0);
    chk("rst_data", out_data, 0);
    chk("rst_type", msg_type, 0);
    chk("rst_bcnt", byte_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-byte message from requester 0, trigger latency
    req_type[0] = 3'b010; req_data[0] = 128'hA5C3; req = 4'b0001;
    @(negedge clk);
    chk("b_gnt_load", gnt, 4'b0001);
    chk("b_trig_early", trig, 0);
    @(negedge clk);
    chk("b_trig", trig, 1);
    chk("b_data", out_data, 128'hA5C3);
    chk("b_type", msg_type, 3'b010);
    chk("b_bcnt", byte_cnt, 7'd2);
    req = 4'd0;
    wait_ack(100, cyc, st, boh);
    chk("b_ack", ack, 4'b0001);
    chk("b_err", err, 0);
    chk("b_gnt_held", gnt, 4'b0001);
    chk("b_data_held", out_data, 128'hA5C3);
    @(negedge clk);
    chk("b_ack_pulse", ack, 0);
    chk("b_gnt_clr", gnt, 0);

    // Reset while waiting for slave idle
    req_type[2] = 3'b001; req_data[2] = 128'h5A; req = 4'b0100;
    cyc = 0;
    while (!model_busy && cyc < 20) begin @(negedge clk); cyc++; end
    chk("c_busy_seen", model_busy, 1);
    repeat (3) @(negedge clk);
    chk("c_gnt_pre", gnt, 4'b0100);
    rst_n = 1'b0; req = 4'd0;
    #1;
    chk("c_gnt_rst", gnt, 0);
    chk("c_trig_rst", trig, 0);
    chk("c_data_rst", out_data, 0);
    chk("c_type_rst", msg_type, 0);
    @(negedge clk);
    rst_n = 1'b1;
    flag = 0;
    repeat (30) begin @(negedge clk); if (ack != 0) flag = 1; end
    chk("c_no_ack", flag, 0);

    // All four held: round-robin from index 0 after reset
    for (int i = 0; i < 4; i++) begin
      req_type[i] = 3'b001; req_data[i] = 128'(8'h10 + i);
    end
    req = 4'b1111;
    @(negedge clk);
    chk("d_first_gnt", gnt, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      wait_ack(100, cyc, st, boh);
      chk($sformatf("d_ack%0d", k), ack, 4'b0001 << (k % 4));
      chk($sformatf("d_onehot%0d", k), boh, 0);
    end
    req = 4'd0;
    repeat (3) @(negedge clk);

    // Receive in progress blocks arbitration
    force_busy = 1'b1; req = 4'b0010; req_data[1] = 128'hBEEF;
    flag = 0;
    repeat (50) begin @(negedge clk); if (gnt != 0) flag = 1; end
    chk("e_blocked", flag, 0);
    force_busy = 1'b0;
    wait_ack(100, cyc, st, boh);
    chk("e_ack", ack, 4'b0010);
    chk("e_err", err, 0);
    chk("e_trig", st, 1);
    req = 4'd0;
    repeat (2) @(negedge clk);

    // Long type with zero bytes: error, no trigger, ack two cycles after request
    req_type[2] = 3'b111; req_bytes[2] = 7'd0; req = 4'b0100;
    wait_ack(20, cyc, st, boh);
    chk("f0_ack", ack, 4'b0100);
    chk("f0_err", err, 1);
    chk("f0_notrig", st, 0);
    chk("f0_lat", cyc, 2);
    req = 4'd0;
    repeat (2) @(negedge clk);
    req_type[3] = 3'b100; req = 4'b1000;
    wait_ack(20, cyc, st, boh);
    chk("f1_ack", ack, 4'b1000);
    chk("f1_err", err, 1);
    chk("f1_notrig", st, 0);
    req = 4'd0;
    repeat (2) @(negedge clk);
    req_type[0] = 3'b111; req_bytes[0] = 7'd17; req = 4'b0001;
    wait_ack(20, cyc, st, boh);
    chk("f2_ack", ack, 4'b0001);
    chk("f2_err", err, 1);
    chk("f2_notrig", st, 0);
    req = 4'd0;
    repeat (2) @(negedge clk);
    req_type[1] = 3'b111; req_bytes[1] = 7'd16; req_data[1] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; req = 4'b0010;
    wait_ack(100, cyc, st, boh);
    chk("f3_ack", ack, 4'b0010);
    chk("f3_err", err, 0);
    chk("f3_trig", st, 1);
    chk("f3_bcnt", byte_cnt, 7'd16);
    chk("f3_type", msg_type, 3'b111);
    chk("f3_data", out_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    req = 4'd0;
    repeat (2) @(negedge clk);

    // Slave never goes busy
    slave_en = 1'b0; req_type[2] = 3'b001; req = 4'b0100;
    cyc = 0;
    while (!trig && cyc < 20) begin @(negedge clk); cyc++; end
    chk("g_trig", trig, 1);
    req = 4'd0;
    wait_ack(40, cyc, st, boh);
`ifdef SPI_TX_ARB_TIMEOUT_EN
    chk("g_tmo_ack", ack, 4'b0100);
    chk("g_tmo_err", err, 1);
    chk("g_tmo_cyc", cyc, 16);
`else
    chk("g_no_ack", ack, 0);
    chk("g_gnt_held", gnt, 4'b0100);
    force_busy = 1'b1;
    @(negedge clk);
    force_busy = 1'b0;
    wait_ack(10, cyc, st, boh);
    chk("g_late_ack", ack, 4'b0100);
    chk("g_late_err", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
